// File: rtl/master_arb_link.sv
// Master-side sequencer for the one-wire arbiter link: REQUEST, ID, grant wait, ACK/NAK, COM, END, release.
// Outputs are registered from the current state, so each line value appears the cycle after state entry.
module master_arb_link #(
  parameter int GRANT_TIMEOUT   = 64,
  parameter int RELEASE_TIMEOUT = 16,
  parameter int MAX_RETRY       = 3,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic [1:0] slave_id,
  input  logic       accept,
  input  logic       xfer_done,
  input  logic       arb_grant,
  output logic       arb_line,
  output logic       busy,
  output logic       com_active,
  output logic       fail,
  output logic       nak_done
);
  localparam int MAX_A = (GRANT_TIMEOUT > RELEASE_TIMEOUT) ? GRANT_TIMEOUT : RELEASE_TIMEOUT;
  localparam int MAX_B = (GAP_CYCLES > 4) ? GAP_CYCLES : 4;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ID, S_WAIT, S_GAP, S_ACK, S_COM, S_END, S_REL
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [1:0]    id_q, id_nxt;
  logic          nak_q, nak_nxt;
  logic          fail_nxt, nak_done_nxt, line_nxt;
  logic [2:0]    ack_pat;

  // Every counting state clears cnt on exit because cnt_nxt defaults to zero.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    retry_nxt    = retry;
    id_nxt       = id_q;
    nak_nxt      = nak_q;
    fail_nxt     = 1'b0;
    nak_done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_REQ;
          id_nxt    = slave_id;
          retry_nxt = '0;
          nak_nxt   = 1'b0;
        end
      end
      S_REQ: begin
        if (cnt == CW'(2)) state_nxt = S_ID;
        else               cnt_nxt   = cnt + 1'b1;
      end
      S_ID: begin
        if (cnt == CW'(1)) state_nxt = S_WAIT;
        else               cnt_nxt   = cnt + 1'b1;
      end
      S_WAIT: begin
        if (arb_grant) begin
          state_nxt = S_ACK;
          nak_nxt   = !accept;
        end else if (cnt == CW'(GRANT_TIMEOUT - 1)) begin
          if (retry < RW'(MAX_RETRY)) begin
            retry_nxt = retry + 1'b1;
            state_nxt = S_GAP;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) state_nxt = S_REQ;
        else                            cnt_nxt   = cnt + 1'b1;
      end
      S_ACK: begin
        if (cnt == CW'(2)) state_nxt = nak_q ? S_REL : S_COM;
        else               cnt_nxt   = cnt + 1'b1;
      end
      S_COM: begin
        // Grant loss outranks a coincident xfer_done.
        if (!arb_grant) begin
          fail_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (xfer_done) begin
          state_nxt = S_END;
        end
      end
      S_END: state_nxt = S_REL;
      S_REL: begin
        if (!arb_grant) begin
          nak_done_nxt = nak_q;
          state_nxt    = S_IDLE;
        end else if (cnt == CW'(RELEASE_TIMEOUT - 1)) begin
          fail_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_pat  = nak_q ? 3'b110 : 3'b101;
    line_nxt = 1'b0;
    case (state)
      S_REQ, S_END: line_nxt = 1'b1;
      S_ID:         line_nxt = (cnt == '0) ? id_q[1] : id_q[0];
      S_ACK: begin
        case (cnt[1:0])
          2'd0:    line_nxt = ack_pat[2];
          2'd1:    line_nxt = ack_pat[1];
          default: line_nxt = ack_pat[0];
        endcase
      end
      default:      line_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      retry      <= '0;
      id_q       <= '0;
      nak_q      <= 1'b0;
      arb_line   <= 1'b0;
      busy       <= 1'b0;
      com_active <= 1'b0;
      fail       <= 1'b0;
      nak_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retry      <= retry_nxt;
      id_q       <= id_nxt;
      nak_q      <= nak_nxt;
      arb_line   <= line_nxt;
      busy       <= (state != S_IDLE);
      com_active <= (state == S_COM);
      fail       <= fail_nxt;
      nak_done   <= nak_done_nxt;
    end
  end
endmodule

// File: tb/tb_master_arb_link.sv
// Bench for master_arb_link: expected traces are built from the protocol timeline with plain
// edge arithmetic, then compared cycle by cycle against the DUT under randomized side stimulus.
module tb_master_arb_link;
  localparam int GT   = 64;
  localparam int RT   = 16;
  localparam int MR   = 3;
  localparam int GAP  = 2;
  localparam int P    = 5 + GT + GAP;
  localparam int MAXL = 420;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       req = 1'b0, accept = 1'b0, xfer_done = 1'b0, arb_grant = 1'b0;
  logic [1:0] slave_id = 2'b00;
  logic       arb_line, busy, com_active, fail, nak_done;

  int checks = 0;
  int errors = 0;
  int scen_len;

  logic       st_req [MAXL], st_acc [MAXL], st_done [MAXL], st_grant [MAXL];
  logic [1:0] st_id  [MAXL];
  logic       e_line [MAXL], e_busy [MAXL], e_com [MAXL], e_fail [MAXL], e_nak [MAXL];

  always #5 clk = ~clk;

  master_arb_link #(
    .GRANT_TIMEOUT(GT), .RELEASE_TIMEOUT(RT), .MAX_RETRY(MR), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .slave_id(slave_id), .accept(accept),
    .xfer_done(xfer_done), .arb_grant(arb_grant), .arb_line(arb_line), .busy(busy),
    .com_active(com_active), .fail(fail), .nak_done(nak_done)
  );

  // Edge at which a grant that rises at edge g is first seen inside a WAIT_GRANT window.
  function automatic int first_grant_edge(input int g);
    int s;
    if (g < 0) return -1;
    for (int a = 0; a <= MR; a++) begin
      s = a * P;
      if (g <= s + 5 + GT) return (g > s + 6) ? g : s + 6;
    end
    return -1;
  endfunction

  task automatic build(input logic [1:0] id, input int g, input logic acc, input int d, input int r);
    int ge, s, idle_e, x, lo, hi;
    for (int k = 0; k < MAXL; k++) begin
      st_req[k] = 0; st_acc[k] = 0; st_done[k] = 0; st_grant[k] = 0; st_id[k] = 0;
      e_line[k] = 0; e_busy[k] = 0; e_com[k] = 0; e_fail[k] = 0; e_nak[k] = 0;
    end
    ge = first_grant_edge(g);
    idle_e = 0;
    x = 0;
    for (int a = 0; a <= MR; a++) begin
      s = a * P;
      for (int k = 1; k <= 3; k++) e_line[s + k] = 1'b1;
      e_line[s + 4] = id[1];
      e_line[s + 5] = id[0];
      if (ge >= 0 && ge <= s + 5 + GT) break;
      if (a == MR) begin
        idle_e = s + 5 + GT;
        e_fail[idle_e] = 1'b1;
      end
    end
    if (ge >= 0) begin
      e_line[ge + 1] = 1'b1;
      e_line[ge + 2] = !acc;
      e_line[ge + 3] = acc;
      lo = (r > ge + 4) ? r : ge + 4;
      if (acc) begin
        if (lo <= d) begin
          x = lo;
          idle_e = x;
          e_fail[x] = 1'b1;
        end else begin
          x = d;
          e_line[d + 1] = 1'b1;
          lo = (r > d + 2) ? r : d + 2;
          if (lo <= d + 1 + RT) idle_e = lo;
          else begin
            idle_e = d + 1 + RT;
            e_fail[idle_e] = 1'b1;
          end
        end
        for (int k = ge + 4; k <= x; k++) e_com[k] = 1'b1;
      end else if (lo <= ge + 3 + RT) begin
        idle_e = lo;
        e_nak[lo] = 1'b1;
      end else begin
        idle_e = ge + 3 + RT;
        e_fail[idle_e] = 1'b1;
      end
    end
    for (int k = 1; k <= idle_e; k++) e_busy[k] = 1'b1;
    scen_len = idle_e + 4;

    st_req[0] = 1'b1;
    st_id[0]  = id;
    for (int k = 0; k < scen_len; k++) begin
      if (k > 0) st_id[k] = 2'($urandom);
      st_acc[k]   = 1'($urandom);
      st_grant[k] = (g >= 0 && k >= g && k < r);
    end
    if (ge >= 0) st_acc[ge] = acc;
    for (int i = 0; i < 3; i++) st_req[$urandom_range(idle_e, 1)] = 1'b1;
    hi = (ge >= 0) ? ge + 3 : scen_len - 1;
    for (int i = 0; i < 2; i++) st_done[$urandom_range(hi, 0)] = 1'b1;
    if (ge >= 0 && acc && d < MAXL) st_done[d] = 1'b1;
  endtask

  task automatic run(input int sid, input int ncyc);
    logic [4:0] expv, obs;
    for (int k = 0; k < ncyc; k++) begin
      req = st_req[k]; slave_id = st_id[k]; accept = st_acc[k];
      xfer_done = st_done[k]; arb_grant = st_grant[k];
      @(posedge clk);
      @(negedge clk);
      expv = {e_line[k], e_busy[k], e_com[k], e_fail[k], e_nak[k]};
      obs  = {arb_line, busy, com_active, fail, nak_done};
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL scen%0d cyc%0d {line,busy,com,fail,nak} got %b exp %b", sid, k, obs, expv);
      end
    end
    req = 0; xfer_done = 0; arb_grant = 0; accept = 0;
  endtask

  // Called at a negedge: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input int sid);
    logic [4:0] obs;
    rstn = 1'b0;
    req = 0; xfer_done = 0; arb_grant = 0; accept = 0;
    #1;
    obs = {arb_line, busy, com_active, fail, nak_done};
    checks++;
    assert (obs === 5'b00000) else begin
      errors++;
      $error("FAIL reset%0d outputs got %b exp 00000", sid, obs);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int g, ge, d, r;
    logic acc;
    @(negedge clk);

    do_reset(1); build(2'b10, 8, 1'b1, 20, 24);   run(1, scen_len);
    do_reset(2); build(2'b10, 8, 1'b0, 20, 24);   run(2, scen_len);
    do_reset(3); build(2'b01, -1, 1'b1, 0, 0);    run(3, scen_len);
    do_reset(4); build(2'b11, 8, 1'b1, 40, 15);   run(4, scen_len);
    // Reset mid ACK shift, then mid COM.
    do_reset(5); build(2'b10, 8, 1'b1, 20, 24);   run(5, 10);
    do_reset(51); build(2'b10, 8, 1'b1, 40, 60);  run(51, 15);
    do_reset(52); build(2'b01, 10, 1'b1, 25, 30); run(52, scen_len);
    do_reset(6); build(2'b01, 8, 1'b1, 20, 1000); run(6, scen_len);
    // Grant on the timeout edge wins; one edge later falls into the retry.
    do_reset(7); build(2'b11, 5 + GT, 1'b1, 5 + GT + 6, 5 + GT + 12); run(7, scen_len);
    do_reset(8); build(2'b10, 6 + GT, 1'b0, 0, P + 20);  run(8, scen_len);
    // xfer_done coincident with grant loss.
    do_reset(9); build(2'b01, 12, 1'b1, 22, 22);  run(9, scen_len);

    for (int i = 0; i < 12; i++) begin
      g   = $urandom_range(150, 2);
      ge  = first_grant_edge(g);
      acc = 1'($urandom);
      d   = ge + 4 + $urandom_range(20, 0);
      r   = ge + 4 + $urandom_range(45, 0);
      do_reset(100 + i);
      build(2'($urandom), g, acc, d, r);
      run(100 + i, scen_len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
